// File: rtl/custom_function_pkg.sv
// custom_function_pkg: shared widths and FSM states for the custom-function table loader
package custom_function_pkg;

    localparam int CF_ADDR_W = 5;
    localparam int CF_DATA_W = 16;
    localparam int CF_DEPTH  = 32;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } cf_state_t;

endpackage

// File: rtl/custom_function_loader.sv
// custom_function_loader: streams a truth table into the LUT-RAM, then serves registered lookups from it
module custom_function_loader
    import custom_function_pkg::*;
#(
    parameter int WORDS = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load_start,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CF_DATA_W-1:0] cfg_data,
    output logic                 load_done,
    input  logic                 lookup_valid,
    output logic                 lookup_ready,
    input  logic [CF_ADDR_W-1:0] lookup_addr,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [CF_DATA_W-1:0] result_data,
    output logic                 ram_we,
    output logic [CF_ADDR_W-1:0] ram_addr,
    output logic [CF_DATA_W-1:0] ram_din,
    input  logic [CF_DATA_W-1:0] ram_dout
);

    localparam logic [CF_ADDR_W-1:0] LAST = CF_ADDR_W'(WORDS - 1);

    cf_state_t            r_state;
    logic [CF_ADDR_W-1:0] r_widx;
    logic                 r_load_done;
    logic                 r_result_valid;
    logic [CF_DATA_W-1:0] r_result_data;
    logic                 w_wr;
    logic                 w_lk;

    assign cfg_ready    = r_state == LOAD;
    assign w_wr         = cfg_ready && cfg_valid;
    assign lookup_ready = (r_state == ACTIVE) && (!r_result_valid || result_ready);
    assign w_lk         = lookup_valid && lookup_ready;
    // The RAM port is shared: writes only exist in LOAD and lookups only in ACTIVE, so they never collide
    assign ram_we       = w_wr;
    assign ram_addr     = w_wr ? r_widx : (w_lk ? lookup_addr : '0);
    assign ram_din      = w_wr ? cfg_data : '0;
    assign load_done    = r_load_done;
    assign result_valid = r_result_valid;
    assign result_data  = r_result_data;

    // Phase control and word counter; a reload from ACTIVE waits until no result is pending
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= EMPTY;
            r_widx      <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
                EMPTY: if (load_start) begin
                    r_state <= LOAD;
                    r_widx  <= '0;
                end
                ACTIVE: if (load_start && !r_result_valid) begin
                    r_state <= LOAD;
                    r_widx  <= '0;
                end
                LOAD: if (w_wr) begin
                    if (r_widx == LAST) begin
                        r_state     <= ACTIVE;
                        r_widx      <= '0;
                        r_load_done <= 1'b1;
                    end else begin
                        r_widx <= r_widx + 1'b1;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    // Result register: capture on accept, drop only when drained without a replacement
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_result_valid <= 1'b0;
            r_result_data  <= '0;
        end else if (w_lk) begin
            r_result_valid <= 1'b1;
            r_result_data  <= ram_dout;
        end else if (result_ready) begin
            r_result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_custom_function_loader.sv
// tb_custom_function_loader: randomized checks of load, lookup and handshake behaviour against a table model
module tb_custom_function_loader;

    logic        clock, reset_n;
    logic        load_start, cfg_valid, cfg_ready, load_done;
    logic [15:0] cfg_data;
    logic        lookup_valid, lookup_ready, result_valid, result_ready;
    logic [4:0]  lookup_addr;
    logic [15:0] result_data;
    logic        ram_we;
    logic [4:0]  ram_addr;
    logic [15:0] ram_din, ram_dout;

    logic        b_load_start, b_cfg_valid, b_cfg_ready, b_load_done;
    logic [15:0] b_cfg_data;
    logic        b_lookup_valid, b_lookup_ready, b_result_valid, b_result_ready;
    logic [4:0]  b_lookup_addr;
    logic [15:0] b_result_data;
    logic        b_ram_we;
    logic [4:0]  b_ram_addr;
    logic [15:0] b_ram_din, b_ram_dout;

    logic [15:0] mem [32];
    logic [15:0] b_mem [32];
    logic [15:0] exp_tab [32];
    logic [15:0] b_exp_tab [32];

    int n_tests = 0;
    int n_fail  = 0;

    custom_function_loader #(.WORDS(32)) u_dut (
        .clock(clock), .reset_n(reset_n), .load_start(load_start),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .load_done(load_done),
        .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_addr(lookup_addr),
        .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    custom_function_loader #(.WORDS(4)) u_dut4 (
        .clock(clock), .reset_n(reset_n), .load_start(b_load_start),
        .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_data(b_cfg_data), .load_done(b_load_done),
        .lookup_valid(b_lookup_valid), .lookup_ready(b_lookup_ready), .lookup_addr(b_lookup_addr),
        .result_valid(b_result_valid), .result_ready(b_result_ready), .result_data(b_result_data),
        .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_din(b_ram_din), .ram_dout(b_ram_dout)
    );

    // LUT-RAM stand-ins: synchronous write, combinational read
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        if (b_ram_we) b_mem[b_ram_addr] <= b_ram_din;
    end
    assign ram_dout   = mem[ram_addr];
    assign b_ram_dout = b_mem[b_ram_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_ready got %b want 0", cfg_ready); end
        n_tests++; if (lookup_ready !== 1'b0) begin n_fail++; $display("FAIL rst_lookup_ready got %b want 0", lookup_ready); end
        n_tests++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL rst_load_done got %b want 0", load_done); end
        n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL rst_result_valid got %b want 0", result_valid); end
        n_tests++; if (result_data !== 16'h0) begin n_fail++; $display("FAIL rst_result_data got %h want 0000", result_data); end
        n_tests++; if ({ram_we, ram_addr, ram_din} !== 22'h0) begin n_fail++; $display("FAIL rst_ram_port got we=%b addr=%0d din=%h want 0", ram_we, ram_addr, ram_din); end
        cyc(); cyc();
        reset_n = 1'b1;
        lookup_valid = 1'b1; lookup_addr = 5'd3;
        #1;
        n_tests++; if (lookup_ready !== 1'b0 || ram_addr !== 5'd0) begin n_fail++; $display("FAIL empty_stall got ready=%b addr=%0d want 0/0", lookup_ready, ram_addr); end
        cyc();
        lookup_valid = 1'b0;
        #1;
        n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL empty_no_result got %b want 0", result_valid); end
    endtask

    task automatic test_full_load(input logic [15:0] base, input logic fixed);
        int we_cnt = 0;
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = fixed ? base : base + 16'(i);
            exp_tab[i] = cfg_data;
            #1;
            if (ram_we === 1'b1) we_cnt++;
            n_tests++; if (cfg_ready !== 1'b1 || ram_addr !== 5'(i) || ram_din !== cfg_data || load_done !== 1'b0) begin
                n_fail++; $display("FAIL load_word[%0d] got rdy=%b addr=%0d din=%h done=%b want 1/%0d/%h/0", i, cfg_ready, ram_addr, ram_din, load_done, i, cfg_data);
            end
            cyc();
        end
        cfg_valid = 1'b0;
        #1;
        n_tests++; if (we_cnt !== 32 || ram_we !== 1'b0) begin n_fail++; $display("FAIL load_we_count got %0d (now %b) want 32 (now 0)", we_cnt, ram_we); end
        n_tests++; if (load_done !== 1'b1 || lookup_ready !== 1'b1 || cfg_ready !== 1'b0) begin
            n_fail++; $display("FAIL load_done_cycle got done=%b lrdy=%b crdy=%b want 1/1/0", load_done, lookup_ready, cfg_ready);
        end
        cyc();
        n_tests++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL load_done_pulse got %b want 0", load_done); end
    endtask

    task automatic test_lookup_throughput();
        int adr [3];
        adr = '{5, 31, 0};
        result_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lookup_valid = 1'b1;
            lookup_addr  = 5'(adr[i]);
            #1;
            n_tests++; if (lookup_ready !== 1'b1 || ram_addr !== 5'(adr[i]) || ram_we !== 1'b0) begin
                n_fail++; $display("FAIL tput_accept[%0d] got rdy=%b addr=%0d we=%b want 1/%0d/0", i, lookup_ready, ram_addr, ram_we, adr[i]);
            end
            if (i > 0) begin
                n_tests++; if (result_valid !== 1'b1 || result_data !== exp_tab[adr[i-1]]) begin
                    n_fail++; $display("FAIL tput_result[%0d] got v=%b d=%h want 1/%h", i - 1, result_valid, result_data, exp_tab[adr[i-1]]);
                end
            end
            cyc();
        end
        lookup_valid = 1'b0;
        #1;
        n_tests++; if (result_valid !== 1'b1 || result_data !== exp_tab[adr[2]]) begin
            n_fail++; $display("FAIL tput_result[2] got v=%b d=%h want 1/%h", result_valid, result_data, exp_tab[adr[2]]);
        end
        cyc();
        n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL tput_drain got %b want 0", result_valid); end
    endtask

    task automatic test_backpressure();
        result_ready = 1'b0;
        lookup_valid = 1'b1; lookup_addr = 5'd3;
        cyc();
        lookup_addr = 5'd4;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++; if (lookup_ready !== 1'b0 || result_valid !== 1'b1 || result_data !== exp_tab[3]) begin
                n_fail++; $display("FAIL bp_hold[%0d] got rdy=%b v=%b d=%h want 0/1/%h", k, lookup_ready, result_valid, result_data, exp_tab[3]);
            end
            cyc();
        end
        result_ready = 1'b1;
        #1;
        n_tests++; if (lookup_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b want 1", lookup_ready); end
        cyc();
        lookup_valid = 1'b0;
        #1;
        n_tests++; if (result_valid !== 1'b1 || result_data !== exp_tab[4]) begin
            n_fail++; $display("FAIL bp_next got v=%b d=%h want 1/%h", result_valid, result_data, exp_tab[4]);
        end
        cyc();
        n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", result_valid); end
    endtask

    task automatic test_redundant_start();
        int acc = 0;
        int k = 0;
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        while (acc < 32 && k < 300) begin
            cfg_valid  = (acc == 7) || ($urandom_range(0, 3) != 0);
            load_start = (acc == 7);
            cfg_data   = 16'($urandom);
            #1;
            n_tests++; if (load_done !== 1'b0 || cfg_ready !== 1'b1 || ram_we !== cfg_valid || (cfg_valid && (ram_addr !== 5'(acc) || ram_din !== cfg_data))) begin
                n_fail++; $display("FAIL redo_word[%0d] got done=%b rdy=%b we=%b addr=%0d din=%h want 0/1/%b/%0d/%h", acc, load_done, cfg_ready, ram_we, ram_addr, ram_din, cfg_valid, acc, cfg_data);
            end
            if (cfg_valid) begin exp_tab[acc] = cfg_data; acc++; end
            k++;
            cyc();
        end
        cfg_valid = 1'b0; load_start = 1'b0;
        #1;
        n_tests++; if (acc < 32) begin n_fail++; $display("FAIL redo_timeout got %0d words want 32", acc); end
        n_tests++; if (load_done !== 1'b1 || lookup_ready !== 1'b1) begin
            n_fail++; $display("FAIL redo_done got done=%b lrdy=%b want 1/1", load_done, lookup_ready);
        end
        cyc();
    endtask

    task automatic test_random_lookups();
        logic        m_valid = 1'b0;
        logic [15:0] m_data = 16'h0;
        for (int i = 0; i < 200; i++) begin
            lookup_valid = ($urandom_range(0, 3) != 0);
            lookup_addr  = 5'($urandom);
            result_ready = ($urandom_range(0, 2) != 0);
            #1;
            n_tests++; if (lookup_ready !== (!m_valid || result_ready) || result_valid !== m_valid || (m_valid && result_data !== m_data)) begin
                n_fail++; $display("FAIL rand_lookup[%0d] got rdy=%b v=%b d=%h want %b/%b/%h", i, lookup_ready, result_valid, result_data, !m_valid || result_ready, m_valid, m_data);
            end
            if (lookup_valid && (!m_valid || result_ready)) begin
                m_valid = 1'b1;
                m_data  = exp_tab[lookup_addr];
            end else if (result_ready) begin
                m_valid = 1'b0;
            end
            cyc();
        end
        lookup_valid = 1'b0; result_ready = 1'b1;
        cyc();
        n_tests++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL rand_drain got %b want 0", result_valid); end
    endtask

    task automatic test_reset_mid_load();
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = 16'($urandom);
            exp_tab[i] = cfg_data;
            cyc();
        end
        cfg_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        n_tests++; if ({cfg_ready, lookup_ready, load_done, result_valid, ram_we} !== 5'b0 || result_data !== 16'h0 || ram_addr !== 5'd0 || ram_din !== 16'h0) begin
            n_fail++; $display("FAIL midrst_outputs got crdy=%b lrdy=%b done=%b v=%b d=%h we=%b addr=%0d din=%h want all 0", cfg_ready, lookup_ready, load_done, result_valid, result_data, ram_we, ram_addr, ram_din);
        end
        cyc();
        reset_n = 1'b1;
        lookup_valid = 1'b1; lookup_addr = 5'd9;
        #1;
        n_tests++; if (lookup_ready !== 1'b0 || cfg_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_empty got lrdy=%b crdy=%b want 0/0", lookup_ready, cfg_ready);
        end
        cyc();
        lookup_valid = 1'b0;
        test_full_load(16'h5555, 1'b1);
        lookup_valid = 1'b1; lookup_addr = 5'd9; result_ready = 1'b1;
        cyc();
        lookup_valid = 1'b0;
        #1;
        n_tests++; if (result_valid !== 1'b1 || result_data !== 16'h5555) begin
            n_fail++; $display("FAIL midrst_lookup got v=%b d=%h want 1/5555", result_valid, result_data);
        end
        cyc();
    endtask

    task automatic test_gapped_load();
        int acc = 0;
        int k = 0;
        b_result_ready = 1'b1;
        b_load_start = 1'b1;
        cyc();
        b_load_start = 1'b0;
        b_lookup_valid = 1'b1; b_lookup_addr = 5'd2;
        while (acc < 4 && k < 40) begin
            b_cfg_valid = (k % 2) == 1;
            b_cfg_data  = 16'($urandom);
            #1;
            n_tests++; if (b_lookup_ready !== 1'b0 || b_load_done !== 1'b0 || b_ram_we !== b_cfg_valid || (b_cfg_valid && b_ram_addr !== 5'(acc))) begin
                n_fail++; $display("FAIL gap_word[%0d] got lrdy=%b done=%b we=%b addr=%0d want 0/0/%b/%0d", acc, b_lookup_ready, b_load_done, b_ram_we, b_ram_addr, b_cfg_valid, acc);
            end
            if (b_cfg_valid) begin b_exp_tab[acc] = b_cfg_data; acc++; end
            k++;
            cyc();
        end
        b_cfg_valid = 1'b0;
        #1;
        n_tests++; if (acc < 4) begin n_fail++; $display("FAIL gap_timeout got %0d words want 4", acc); end
        n_tests++; if (b_load_done !== 1'b1 || b_lookup_ready !== 1'b1 || b_ram_addr !== 5'd2 || b_ram_we !== 1'b0) begin
            n_fail++; $display("FAIL gap_done got done=%b lrdy=%b addr=%0d we=%b want 1/1/2/0", b_load_done, b_lookup_ready, b_ram_addr, b_ram_we);
        end
        cyc();
        b_lookup_valid = 1'b0;
        #1;
        n_tests++; if (b_result_valid !== 1'b1 || b_result_data !== b_exp_tab[2]) begin
            n_fail++; $display("FAIL gap_result got v=%b d=%h want 1/%h", b_result_valid, b_result_data, b_exp_tab[2]);
        end
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin mem[i] = 16'h0; b_mem[i] = 16'h0; exp_tab[i] = 16'h0; b_exp_tab[i] = 16'h0; end
        load_start = 1'b0; cfg_valid = 1'b0; cfg_data = 16'h0;
        lookup_valid = 1'b0; lookup_addr = 5'd0; result_ready = 1'b1;
        b_load_start = 1'b0; b_cfg_valid = 1'b0; b_cfg_data = 16'h0;
        b_lookup_valid = 1'b0; b_lookup_addr = 5'd0; b_result_ready = 1'b1;
        test_reset();
        test_full_load(16'hA000, 1'b0);
        test_lookup_throughput();
        test_backpressure();
        test_redundant_start();
        test_random_lookups();
        test_reset_mid_load();
        test_gapped_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
